fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core.
//  - Keeps its own pipeline of destination tags, one per stage from EX to the last forwarding stage.
//  - Produces a per-source forwarding select for the instruction in EX.
//  - Produces a load-use stall for the instruction in ID.
//  - Generalises the fixed 2-source, 2-stage forwarding logic to N sources, N stages and a configurable load latency.

---
 rtl/fwd_pkg.sv | 24 ++
 rtl/fwd_prio_match.sv | 33 +++
 rtl/fwd_hazard_unit.sv | 151 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package fwd_pkg;

  // Widest register index a tag can carry; narrower indices are zero-extended.
  localparam int TAG_AW = 6;

  // fwd_sel encoding: 0 selects the register file, k selects producer stage k.
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic              regWrite;
    logic              isLoad;
    logic [TAG_AW-1:0] rd;
  } fwd_tag_t;

  // Width of a forwarding select able to encode 0..depth.
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// Youngest-producer search: finds the lowest-index tag writing a given source register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from its inputs.
module fwd_prio_match
  import fwd_pkg::*;
#(
  parameter int N    = 2,
  parameter int IW   = 2,
  parameter int BASE = 1
) (
  input  fwd_tag_t [N-1:0]  tags,
  input  logic [TAG_AW-1:0] src,
  output logic              hit,
  output logic [IW-1:0]     idx,
  output logic              is_load
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int p = N - 1; p >= 0; p--) begin
      if (tags[p].valid && tags[p].regWrite &&
          (tags[p].rd != '0) && (tags[p].rd == src)) begin
        hit     = 1'b1;
        idx     = IW'(p + BASE);
        is_load = tags[p].isLoad;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select for the EX instruction and load-use stall for the ID instruction (FWD_STATS_EN adds counters).
// Latency: fwd_sel and stall are combinational (zero cycles); the tag pipeline advances one stage per clock.
// Backpressure: stall asks the core to hold IF/ID; producer stages never stall, EX takes a bubble instead.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC   = 2,
  parameter  int FWD_DEPTH = 2,
  parameter  int REG_AW    = 5,
  parameter  int LOAD_LAT  = 1,
  localparam int SELW      = sel_w(FWD_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic                            id_regWrite,
  input  logic                            id_isLoad,
  input  logic [REG_AW-1:0]               id_rd,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]              id_rs_used,
  input  logic                            flush,
  output logic                            stall,
  output logic [NUM_SRC-1:0][SELW-1:0]    fwd_sel
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                     stall_cnt,
  output logic [31:0]                     fwd_cnt
`endif
);

  // tag[0] is the EX consumer, tag[1..FWD_DEPTH] are the forwarding producers.
  // LOAD_LAT must stay below FWD_DEPTH, otherwise load data is never forwardable.
  fwd_tag_t [FWD_DEPTH:0]           tag;
  fwd_tag_t                         id_tag;
  logic [NUM_SRC-1:0][REG_AW-1:0]   ex_rs;
  logic [NUM_SRC-1:0]               ex_rs_used;
  logic [NUM_SRC-1:0]               stall_src;
  logic [NUM_SRC-1:0]               escape;

  // Pack the ID instruction into the tag format.
  always_comb begin
    id_tag          = '0;
    id_tag.valid    = id_valid;
    id_tag.regWrite = id_regWrite;
    id_tag.isLoad   = id_isLoad;
    id_tag.rd       = TAG_AW'(id_rd);
  end

  // Producers shift every cycle; EX loads from ID unless a stall or flush forces a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag        <= '0;
      ex_rs      <= '0;
      ex_rs_used <= '0;
    end else begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        tag[k] <= tag[k-1];
      end
      if (stall || flush) begin
        tag[0]     <= '0;
        ex_rs      <= '0;
        ex_rs_used <= '0;
      end else begin
        tag[0]     <= id_tag;
        ex_rs      <= id_rs;
        ex_rs_used <= id_rs_used;
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic            ex_hit;
    logic            ex_ld;
    logic [SELW-1:0] ex_idx;
    logic            id_hit;
    logic            id_ld;
    logic [SELW-1:0] id_idx;

    // EX source against producers 1..FWD_DEPTH.
    fwd_prio_match #(
      .N    (FWD_DEPTH),
      .IW   (SELW),
      .BASE (1)
    ) u_ex_match (
      .tags    (tag[FWD_DEPTH:1]),
      .src     (TAG_AW'(ex_rs[i])),
      .hit     (ex_hit),
      .idx     (ex_idx),
      .is_load (ex_ld)
    );

    // ID source against stages 0..FWD_DEPTH-1 (one stage younger than EX sees).
    fwd_prio_match #(
      .N    (FWD_DEPTH),
      .IW   (SELW),
      .BASE (0)
    ) u_id_match (
      .tags    (tag[FWD_DEPTH-1:0]),
      .src     (TAG_AW'(id_rs[i])),
      .hit     (id_hit),
      .idx     (id_idx),
      .is_load (id_ld)
    );

    // A load whose data is not yet available must never be forwarded.
    assign escape[i]  = ex_hit && ex_ld && (int'(ex_idx) <= LOAD_LAT);
    assign fwd_sel[i] = (ex_hit && !escape[i]) ? ex_idx : SELW'(FWD_RF);

    // Stall while the youngest writer of this source is a load too young to forward.
    assign stall_src[i] = id_valid && id_rs_used[i] && (id_rs[i] != '0) &&
                          id_hit && id_ld && (int'(id_idx) < LOAD_LAT);

    // A used source reaching EX behind an immature load means the stall logic let it through.
    a_no_escape : assert property (@(posedge clk) disable iff (rst)
      !(escape[i] && tag[0].valid && ex_rs_used[i]));
  end

  assign stall = |stall_src;

`ifdef FWD_STATS_EN
  logic fwd_any;

  // Any used source of a real EX instruction taking a bypass this cycle.
  always_comb begin
    fwd_any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (tag[0].valid && ex_rs_used[i] && (fwd_sel[i] != SELW'(FWD_RF))) begin
        fwd_any = 1'b1;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (fwd_any && (fwd_cnt != '1)) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end
`else
  // Statistics disabled: no counter state and no stats ports.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit: default instance plus a FWD_DEPTH=3 / LOAD_LAT=2 instance.
// Latency: inputs driven 1 ns after posedge, outputs compared on the following negedge.
// Backpressure: the bench re-presents the ID instruction itself while stall is high.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic            valid;
    logic            rw;
    logic            ld;
    logic [4:0]      rd;
    logic [1:0][4:0] rs;
    logic [1:0]      used;
  } id_t;

  localparam id_t IDLE = '0;

  logic            clk = 1'b0;
  logic            rst;
  id_t             id_a, id_b;
  logic            flush_a, flush_b;
  logic            stall_a, stall_b;
  logic [1:0][1:0] sel_a, sel_b;
  bit              on_b;
  int              n_vec  = 0;
  int              n_miss = 0;
`ifdef FWD_STATS_EN
  logic [31:0] a_stall_cnt, a_fwd_cnt, b_stall_cnt, b_fwd_cnt;
  logic [31:0] s0, f0;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit u_a (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_a.valid),
    .id_regWrite (id_a.rw),
    .id_isLoad   (id_a.ld),
    .id_rd       (id_a.rd),
    .id_rs       (id_a.rs),
    .id_rs_used  (id_a.used),
    .flush       (flush_a),
    .stall       (stall_a),
    .fwd_sel     (sel_a)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt   (a_stall_cnt),
    .fwd_cnt     (a_fwd_cnt)
`endif
  );

  fwd_hazard_unit #(
    .FWD_DEPTH (3),
    .LOAD_LAT  (2)
  ) u_b (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_b.valid),
    .id_regWrite (id_b.rw),
    .id_isLoad   (id_b.ld),
    .id_rd       (id_b.rd),
    .id_rs       (id_b.rs),
    .id_rs_used  (id_b.used),
    .flush       (flush_b),
    .stall       (stall_b),
    .fwd_sel     (sel_b)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt   (b_stall_cnt),
    .fwd_cnt     (b_fwd_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic id_t op(input logic rw, input logic ld, input logic [4:0] rd,
                             input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    id_t v;
    v.valid = 1'b1;
    v.rw    = rw;
    v.ld    = ld;
    v.rd    = rd;
    v.rs[0] = rs0;
    v.rs[1] = rs1;
    v.used  = used;
    return v;
  endfunction

  function automatic id_t alu(input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1);
    return op(1'b1, 1'b0, rd, rs0, rs1, 2'b11);
  endfunction

  function automatic id_t lw(input logic [4:0] rd, input logic [4:0] rs0);
    return op(1'b1, 1'b1, rd, rs0, 5'd0, 2'b01);
  endfunction

  // One cycle: present ID to the selected instance (the other idles), end at negedge.
  task automatic cyc(input id_t v, input logic fl = 1'b0);
    @(posedge clk);
    #1;
    if (on_b) begin
      id_b = v; flush_b = fl; id_a = IDLE; flush_a = 1'b0;
    end else begin
      id_a = v; flush_a = fl; id_b = IDLE; flush_b = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (4) cyc(IDLE);
  endtask

  initial begin
    rst = 1'b1; id_a = IDLE; id_b = IDLE; flush_a = 1'b0; flush_b = 1'b0; on_b = 1'b0;
    #3;
    check_eq("rst_stall_a", 32'(stall_a), 0);
    check_eq("rst_sel_a",   32'(sel_a),   0);
    check_eq("rst_stall_b", 32'(stall_b), 0);
    check_eq("rst_sel_b",   32'(sel_b),   0);
`ifdef FWD_STATS_EN
    check_eq("rst_stall_cnt", a_stall_cnt, 0);
    check_eq("rst_fwd_cnt",   a_fwd_cnt,   0);
`endif
    #10 rst = 1'b0;

    // Back-to-back dependency: distance 1, 2, 3.
    cyc(alu(5'd5, 5'd1, 5'd2));
    check_eq("s1_no_stall", 32'(stall_a), 0);
    cyc(alu(5'd6, 5'd5, 5'd0));
    cyc(IDLE);
    check_eq("s1_dist1", 32'(sel_a[0]), 1);
    drain();
    cyc(alu(5'd5, 5'd1, 5'd2)); cyc(IDLE); cyc(alu(5'd6, 5'd5, 5'd0)); cyc(IDLE);
    check_eq("s1_dist2", 32'(sel_a[0]), 2);
    drain();
    cyc(alu(5'd5, 5'd1, 5'd2)); cyc(IDLE); cyc(IDLE); cyc(alu(5'd6, 5'd5, 5'd0)); cyc(IDLE);
    check_eq("s1_dist3", 32'(sel_a[0]), 0);

    // Youngest writer wins; x0 never forwards or stalls.
    drain();
    cyc(alu(5'd7, 5'd1, 5'd2)); cyc(alu(5'd7, 5'd1, 5'd2)); cyc(alu(5'd8, 5'd7, 5'd7)); cyc(IDLE);
    check_eq("s2_youngest0", 32'(sel_a[0]), 1);
    check_eq("s2_youngest1", 32'(sel_a[1]), 1);
    drain();
    cyc(lw(5'd0, 5'd2)); cyc(alu(5'd8, 5'd0, 5'd0));
    check_eq("s2_x0_stall", 32'(stall_a), 0);
    drain();
    cyc(alu(5'd0, 5'd1, 5'd2)); cyc(alu(5'd8, 5'd0, 5'd0)); cyc(IDLE);
    check_eq("s2_x0_fwd", 32'(sel_a), 0);

    // Load-use: one stall, bubble in EX, then forward from stage 2.
    drain();
`ifdef FWD_STATS_EN
    s0 = a_stall_cnt; f0 = a_fwd_cnt;
`endif
    cyc(alu(5'd9, 5'd1, 5'd2)); cyc(lw(5'd3, 5'd2)); cyc(alu(5'd4, 5'd3, 5'd9));
    check_eq("s3_stall", 32'(stall_a), 1);
    cyc(alu(5'd4, 5'd3, 5'd9));
    check_eq("s3_stall_end", 32'(stall_a), 0);
    check_eq("s3_bubble",    32'(sel_a[1]), 0);
    cyc(IDLE);
    check_eq("s3_load_fwd",  32'(sel_a[0]), 2);
    check_eq("s3_rf_src1",   32'(sel_a[1]), 0);
    cyc(IDLE);
`ifdef FWD_STATS_EN
    check_eq("s3_stall_cnt", a_stall_cnt - s0, 1);
    check_eq("s3_fwd_cnt",   a_fwd_cnt - f0,   1);
`endif

    // LOAD_LAT=2, FWD_DEPTH=3: two stall cycles, then stage 3.
    on_b = 1'b1;
    drain();
    cyc(lw(5'd3, 5'd2)); cyc(alu(5'd4, 5'd3, 5'd1));
    check_eq("s3b_stall1", 32'(stall_b), 1);
    cyc(alu(5'd4, 5'd3, 5'd1));
    check_eq("s3b_stall2", 32'(stall_b), 1);
    cyc(alu(5'd4, 5'd3, 5'd1));
    check_eq("s3b_stall_end", 32'(stall_b), 0);
    cyc(IDLE);
    check_eq("s3b_load_fwd", 32'(sel_b[0]), 3);
    on_b = 1'b0;

    // Younger non-load writer masks the load; unused source never stalls.
    drain();
    cyc(lw(5'd3, 5'd2)); cyc(op(1'b1, 1'b0, 5'd3, 5'd2, 5'd0, 2'b01));
    check_eq("s4_addi_nostall", 32'(stall_a), 0);
    cyc(op(1'b1, 1'b0, 5'd5, 5'd3, 5'd0, 2'b01));
    check_eq("s4_masked", 32'(stall_a), 0);
    cyc(IDLE);
    check_eq("s4_fwd_addi", 32'(sel_a[0]), 1);
    drain();
    cyc(lw(5'd3, 5'd2)); cyc(op(1'b1, 1'b0, 5'd5, 5'd3, 5'd3, 2'b00));
    check_eq("s4_unused", 32'(stall_a), 0);
    cyc(IDLE);
    check_eq("s4_no_early_load", 32'(sel_a[0]), 0);

    // Flush bubbles EX, with and without a concurrent stall.
    drain();
    cyc(alu(5'd9, 5'd1, 5'd2)); cyc(alu(5'd4, 5'd9, 5'd9), 1'b1);
    check_eq("s5_flush_nostall", 32'(stall_a), 0);
    cyc(IDLE);
    check_eq("s5_flush_bubble", 32'(sel_a), 0);
    drain();
    cyc(alu(5'd9, 5'd1, 5'd2)); cyc(lw(5'd3, 5'd2)); cyc(alu(5'd4, 5'd3, 5'd9), 1'b1);
    check_eq("s5_flush_stall", 32'(stall_a), 1);
    cyc(IDLE);
    check_eq("s5_flush_stall_bubble", 32'(sel_a), 0);

    // Asynchronous reset mid-stream clears outputs immediately.
    drain();
    cyc(alu(5'd9, 5'd1, 5'd2)); cyc(lw(5'd3, 5'd9)); cyc(alu(5'd4, 5'd3, 5'd0));
    check_eq("s5_pre_rst_fwd",   32'(sel_a[0]), 1);
    check_eq("s5_pre_rst_stall", 32'(stall_a), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("s5_rst_stall", 32'(stall_a), 0);
    check_eq("s5_rst_sel",   32'(sel_a),   0);
    #1 rst = 1'b0;
    drain();

`ifdef FWD_STATS_EN
    // Saturation of the stall counter.
    force u_a.stall_cnt = 32'hFFFF_FFFE;
    #1 release u_a.stall_cnt;
    repeat (3) begin
      cyc(lw(5'd3, 5'd2)); cyc(alu(5'd4, 5'd3, 5'd1)); cyc(alu(5'd4, 5'd3, 5'd1));
    end
    cyc(IDLE);
    check_eq("s6_stall_sat", a_stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
